// File: rtl/control_sequencer_pkg.sv
// Shared SAP definitions: opcodes, control-word bit positions, T-state codes.
// The ALU, the datapath and the bench all read these, so the bit map lives in one place.
package sap_defs;

   localparam int CW_BITS = 19;

   // control-word bit positions, LSB first
   localparam int B_CP    = 0;
   localparam int B_EP    = 1;
   localparam int B_EJ    = 2;
   localparam int B_EU    = 3;
   localparam int B_ADD   = 4;
   localparam int B_SUB   = 5;
   localparam int B_AND   = 6;
   localparam int B_OR    = 7;
   localparam int B_XOR   = 8;
   localparam int B_NOT   = 9;
   localparam int B_LA    = 10;
   localparam int B_EA    = 11;
   localparam int B_LB    = 12;
   localparam int B_LM    = 13;
   localparam int B_CE    = 14;
   localparam int B_WE    = 15;
   localparam int B_L1    = 16;
   localparam int B_EI    = 17;
   localparam int B_L0    = 18;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_OUT = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_JC  = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;
   localparam logic [2:0] T5 = 3'd5;
   localparam logic [2:0] T_LAST = T5;

   typedef enum logic {SEQ_RUN, SEQ_HALT} seq_state_e;

   function automatic logic [CW_BITS-1:0] cw(input int b);
      return CW_BITS'(1) << b;
   endfunction

   // ALU operation-select bit for the two-operand ops
   function automatic logic [CW_BITS-1:0] alu_sel(input logic [3:0] op);
      case (op)
         OP_ADD:  return cw(B_ADD);
         OP_SUB:  return cw(B_SUB);
         OP_AND:  return cw(B_AND);
         OP_OR:   return cw(B_OR);
         OP_XOR:  return cw(B_XOR);
         default: return '0;
      endcase
   endfunction

   function automatic logic is_alu2(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/control_sequencer_microstep_decode.sv
// Pure microstep ROM: {opcode, T-state, flags} -> {control word, last step, halt request}.
module microstep_decode
   import sap_defs::*;
#(
   parameter int OPW = 4,
   parameter int CWW = 19
) (
   input  logic [OPW-1:0] opcode,
   input  logic [2:0]     t_state,
   input  logic           flag_z,
   input  logic           flag_c,
   output logic [CWW-1:0] ctrl,
   output logic           last,
   output logic           is_hlt
);

   logic       hi_set;
   logic [3:0] op;

   generate
      if (OPW > 4) begin : g_hi
         assign hi_set = |opcode[OPW-1:4];
      end else begin : g_no_hi
         assign hi_set = 1'b0;
      end
   endgenerate

   // any bit above the 4-bit opcode space turns the instruction into a NOP
   assign op = hi_set ? OP_NOP : opcode[3:0];

   always_comb begin
      ctrl   = '0;
      last   = 1'b0;
      is_hlt = 1'b0;
      case (t_state)
         T0: ctrl = cw(B_EP) | cw(B_LM);
         T1: ctrl = cw(B_CE) | cw(B_L1);
         T2: begin
            ctrl = cw(B_CP);
            case (op)
               OP_LDA, OP_STA, OP_OUT, OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_XOR, OP_NOT, OP_JMP, OP_JZ, OP_JC, OP_HLT: last = 1'b0;
               default: last = 1'b1;
            endcase
         end
         T3: begin
            case (op)
               OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT:
                  ctrl = cw(B_EI) | cw(B_LM);
               OP_OUT: begin
                  ctrl = cw(B_EA) | cw(B_L0);
                  last = 1'b1;
               end
               OP_JMP: begin
                  ctrl = cw(B_EI) | cw(B_EJ);
                  last = 1'b1;
               end
               OP_JZ: begin
                  ctrl = flag_z ? (cw(B_EI) | cw(B_EJ)) : '0;
                  last = 1'b1;
               end
               OP_JC: begin
                  ctrl = flag_c ? (cw(B_EI) | cw(B_EJ)) : '0;
                  last = 1'b1;
               end
               OP_HLT:  is_hlt = 1'b1;
               default: last = 1'b1;
            endcase
         end
         T4: begin
            case (op)
               OP_LDA: begin
                  ctrl = cw(B_CE) | cw(B_LA);
                  last = 1'b1;
               end
               OP_STA: begin
                  ctrl = cw(B_EA) | cw(B_WE);
                  last = 1'b1;
               end
               OP_NOT: begin
                  ctrl = cw(B_EU) | cw(B_NOT) | cw(B_LA);
                  last = 1'b1;
               end
               default: begin
                  if (is_alu2(op)) ctrl = cw(B_CE) | cw(B_LB);
                  else             last = 1'b1;
               end
            endcase
         end
         T5: begin
            if (is_alu2(op)) ctrl = cw(B_EU) | alu_sel(op) | cw(B_LA);
            last = 1'b1;
         end
         default: last = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// SAP control sequencer: T-state counter, halt latch and run/step gating around the microstep decoder.
module control_sequencer
   import sap_defs::*;
#(
   parameter int OPW = 4,
   parameter int CWW = 19
) (
   input  logic           CLK,
   input  logic           CLR,
   input  logic [OPW-1:0] opcode,
   input  logic           flag_z,
   input  logic           flag_c,
   input  logic           run,
   input  logic           step,
   output logic [CWW-1:0] ctrl,
   output logic [2:0]     t_state,
   output logic           halted,
   output logic           instr_done
);

   seq_state_e     state, state_nxt;
   logic [2:0]     t_cnt, t_nxt;
   logic           advance;
   logic           dec_last, last, is_hlt;
   logic [CWW-1:0] dec_ctrl;

   assign advance = run | step;

   microstep_decode #(
      .OPW (OPW),
      .CWW (CWW)
   ) u_dec (
      .opcode  (opcode),
      .t_state (t_cnt),
      .flag_z  (flag_z),
      .flag_c  (flag_c),
      .ctrl    (dec_ctrl),
      .last    (dec_last),
      .is_hlt  (is_hlt)
   );

   // T5 always terminates, so the counter can never walk into codes 6/7
   assign last = dec_last | (t_cnt >= T_LAST);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= SEQ_RUN;
         t_cnt <= T0;
      end else begin
         state <= state_nxt;
         t_cnt <= t_nxt;
      end
   end

   // CLR also masks the combinational outputs so they drop without waiting for a clock
   always_comb begin
      state_nxt  = state;
      t_nxt      = t_cnt;
      ctrl       = '0;
      instr_done = 1'b0;
      case (state)
         SEQ_RUN: begin
            instr_done = last & ~CLR;
            if (advance && !CLR) ctrl = dec_ctrl;
            if (advance) begin
               if (is_hlt)    state_nxt = SEQ_HALT;
               else if (last) t_nxt     = T0;
               else           t_nxt     = t_cnt + 3'd1;
            end
         end
         SEQ_HALT: ;
         default: state_nxt = SEQ_RUN;
      endcase
   end

   assign t_state = t_cnt;
   assign halted  = (state == SEQ_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (OPW=6 so the wide-opcode NOP case is reachable).
module tb_control_sequencer;
   import sap_defs::*;

   localparam int OPW = 6;
   localparam int CWW = 19;

   logic           CLK = 1'b0;
   logic           CLR;
   logic [OPW-1:0] opcode;
   logic           flag_z, flag_c, run, step;
   logic [CWW-1:0] ctrl;
   logic [2:0]     t_state;
   logic           halted, instr_done;

   int n_chk = 0;
   int n_err = 0;

   control_sequencer #(.OPW(OPW), .CWW(CWW)) dut (
      .CLK        (CLK),
      .CLR        (CLR),
      .opcode     (opcode),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .run        (run),
      .step       (step),
      .ctrl       (ctrl),
      .t_state    (t_state),
      .halted     (halted),
      .instr_done (instr_done)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] m(input int b);
      return 32'(1) << b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge CLK);
      #1;
   endtask

   logic [31:0] f0, f1, f2;
   logic [31:0] add_x [6];
   logic [31:0] lda_x [5];
   logic [31:0] sub_x [6];
   int p;

   initial begin
      f0 = m(B_EP) | m(B_LM);
      f1 = m(B_CE) | m(B_L1);
      f2 = m(B_CP);
      add_x = '{f0, f1, f2, m(B_EI) | m(B_LM), m(B_CE) | m(B_LB), m(B_EU) | m(B_ADD) | m(B_LA)};
      sub_x = '{f0, f1, f2, m(B_EI) | m(B_LM), m(B_CE) | m(B_LB), m(B_EU) | m(B_SUB) | m(B_LA)};
      lda_x = '{f0, f1, f2, m(B_EI) | m(B_LM), m(B_CE) | m(B_LA)};

      CLR = 1'b1; run = 1'b0; step = 1'b0; opcode = '0; flag_z = 1'b0; flag_c = 1'b0;
      #2;
      chk("rst_t", 32'(t_state), 0);
      chk("rst_halt", 32'(halted), 0);
      chk("rst_ctrl", 32'(ctrl), 0);
      chk("rst_done", 32'(instr_done), 0);
      edge1();
      CLR = 1'b0;

      // ADD in free-run
      opcode = 6'h04; run = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("add_t%0d", k), 32'(t_state), 32'(k));
         chk($sformatf("add_ctrl%0d", k), 32'(ctrl), add_x[k]);
         chk($sformatf("add_done%0d", k), 32'(instr_done), 32'(k == 5));
         edge1();
      end
      chk("add_wrap", 32'(t_state), 0);

      // JZ not taken, then taken with step also held high
      for (int z = 0; z < 2; z++) begin
         opcode = 6'h0B; flag_z = z[0]; step = z[0];
         #1;
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("jz%0d_t%0d", z, k), 32'(t_state), 32'(k));
            if (k == 3) chk($sformatf("jz%0d_ctrl3", z), 32'(ctrl), z ? (m(B_EI) | m(B_EJ)) : 0);
            chk($sformatf("jz%0d_done%0d", z, k), 32'(instr_done), 32'(k == 3));
            edge1();
         end
         chk($sformatf("jz%0d_wrap", z), 32'(t_state), 0);
      end
      flag_z = 1'b0; step = 1'b0;

      // LDA single-stepped, one pulse every third clock
      opcode = 6'h01; run = 1'b0; p = 0;
      for (int c = 0; c < 15; c++) begin
         step = (c % 3 == 0);
         #1;
         chk($sformatf("lda_t_c%0d", c), 32'(t_state), 32'(p));
         chk($sformatf("lda_ctrl_c%0d", c), 32'(ctrl), step ? lda_x[p] : 0);
         if (step) chk($sformatf("lda_done_c%0d", c), 32'(instr_done), 32'(p == 4));
         edge1();
         if (c % 3 == 0) p = (p == 4) ? 0 : p + 1;
      end
      step = 1'b0;
      chk("lda_end_t", 32'(t_state), 0);

      // opcode with bit 4 set decodes as NOP
      opcode = 6'h14; run = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("nop_t%0d", k), 32'(t_state), 32'(k));
         chk($sformatf("nop_done%0d", k), 32'(instr_done), 32'(k == 2));
         edge1();
      end
      chk("nop_wrap", 32'(t_state), 0);

      // SUB aborted by CLR at T4, then refetched cleanly
      opcode = 6'h05;
      #1;
      for (int k = 0; k < 4; k++) edge1();
      chk("sub_t4", 32'(t_state), 4);
      chk("sub_ctrl4", 32'(ctrl), sub_x[4]);
      #2;
      CLR = 1'b1;
      #1;
      chk("sub_clr_t", 32'(t_state), 0);
      chk("sub_clr_ctrl", 32'(ctrl), 0);
      chk("sub_clr_done", 32'(instr_done), 0);
      #1;
      CLR = 1'b0;
      #1;
      chk("sub_re_ctrl0", 32'(ctrl), sub_x[0]);
      for (int k = 1; k < 6; k++) begin
         edge1();
         chk($sformatf("sub_re_t%0d", k), 32'(t_state), 32'(k));
         chk($sformatf("sub_re_ctrl%0d", k), 32'(ctrl), sub_x[k]);
      end
      edge1();
      chk("sub_wrap", 32'(t_state), 0);

      // HLT freezes the sequencer until CLR
      opcode = 6'h0F;
      #1;
      for (int k = 0; k < 3; k++) edge1();
      chk("hlt_t3", 32'(t_state), 3);
      chk("hlt_ctrl3", 32'(ctrl), 0);
      edge1();
      chk("hlt_halted", 32'(halted), 1);
      for (int i = 0; i < 10; i++) begin
         step = i[0];
         edge1();
         chk($sformatf("hlt_h%0d", i), 32'(halted), 1);
         chk($sformatf("hlt_c%0d", i), 32'(ctrl), 0);
         chk($sformatf("hlt_t%0d", i), 32'(t_state), 3);
      end
      step = 1'b0;
      #2;
      CLR = 1'b1;
      #1;
      chk("hlt_clr_h", 32'(halted), 0);
      chk("hlt_clr_t", 32'(t_state), 0);
      CLR = 1'b0;
      edge1();
      chk("hlt_after_t", 32'(t_state), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 4: opcode width; legal range 4..8.
REQ-002 SHALL have parameter CWW, default 19: control-word width; fixed by the shared bit map.
REQ-003 SHALL have ports CLK input 1 (clock, rising edge) and CLR input 1 (reset, asynchronous, active-high).
REQ-004 SHALL have port opcode input OPW: instruction register opcode field, sampled combinationally.
REQ-005 SHALL have ports flag_z input 1 (ALU zero flag) and flag_c input 1 (ALU carry flag).
REQ-006 SHALL have ports run input 1 (1 = free-run; 0 = single-step) and step input 1 (one-CLK advance request, used only when run=0).
REQ-007 SHALL have port ctrl output CWW, bit map LSB first: Cp Ep Ej Eu Add Sub AndOp OrOp XorOp NotOp La Ea Lb Lm CE We L1 Ei L0.
REQ-008 SHALL have ports t_state output 3 (current T-state), halted output 1 (halt state active) and instr_done output 1 (high in the final T-state of an instruction).

Function
REQ-009 SHALL define advance = run | step; T-state, halt state and instr_done SHALL change only on a CLK edge where advance=1.
REQ-010 SHALL drive ctrl to all-zero in every cycle where advance=0 or halted=1.
REQ-011 SHALL run fetch for every opcode: T0 Ep,Lm; T1 CE,L1; T2 Cp.
REQ-012 SHALL decode opcodes 0x0-0xF in the low 4 bits; a nonzero bit above bit 3 SHALL decode as NOP.
REQ-013 SHALL decode NOP (0x0 and every undefined code) with last step T2.
REQ-014 SHALL decode LDA 0x1 as T3 Ei,Lm then T4 CE,La; last step T4.
REQ-015 SHALL decode STA 0x2 as T3 Ei,Lm then T4 Ea,We; last step T4.
REQ-016 SHALL decode OUT 0x3 as T3 Ea,L0; last step T3.
REQ-017 SHALL decode ADD/SUB/AND/OR/XOR (0x4-0x8) as T3 Ei,Lm; T4 CE,Lb; T5 Eu plus the matching op bit plus La; last step T5.
REQ-018 SHALL decode NOT 0x9 as T3 Ei,Lm; T4 Eu,NotOp,La; last step T4.
REQ-019 SHALL decode JMP 0xA as T3 Ei,Ej; last step T3.
REQ-020 SHALL decode JZ 0xB and JC 0xC as T3 Ei,Ej when flag_z (JZ) or flag_c (JC) is 1 at T3, else ctrl zero; last step T3 either way.
REQ-021 SHALL decode HLT 0xF as T3 ctrl zero and enter HALT on the next advancing edge.
REQ-022 SHALL assert instr_done combinationally in the last step; the next advancing edge SHALL load T0.
REQ-023 SHALL leave HALT only by CLR; run and step SHALL have no effect in HALT.
REQ-024 SHALL, when step and run are both 1, advance exactly once per CLK, identical to run alone.
REQ-025 SHALL clamp the T-state counter at T5 as a last step; no T-state code above 5 SHALL be reachable.

Reset
REQ-026 SHALL, on CLR high, immediately force t_state=0, halted=0, instr_done=0 and ctrl=0, regardless of CLK.
REQ-027 SHALL, on CLR release mid-instruction, restart at T0 fetch on the first advancing edge; the aborted instruction SHALL have no further effect.

Structure
REQ-028 SHALL place opcode constants, ctrl bit indices and the T-state encoding in the shared header sap_defs, used by ALU, datapath and bench.
REQ-029 SHALL split into a natural sub-module, microstep_decode: combinational {opcode, t_state, flags} -> {ctrl, last}; the parent SHALL hold the counter, halt register and step gating.

Verification
REQ-030 SHALL test run=1, ADD 0x4: t_state 0..5, ctrl at T5 = Eu|Add|La, instr_done at T5 only, t_state=0 next cycle.
REQ-031 SHALL test JZ with flag_z=0: T3 ctrl=0, back to T0 after 4 cycles. Repeat with flag_z=1: T3 ctrl=Ei|Ej.
REQ-032 SHALL test run=0, step pulsed every 3rd CLK on LDA: ctrl nonzero only in pulse cycles, 5 pulses to complete.
REQ-033 SHALL test HLT then 10 run cycles: halted=1, ctrl=0, t_state frozen; CLR -> halted=0, t_state=0.
REQ-034 SHALL test CLR asserted between edges at T4 of SUB: t_state=0 and ctrl=0 immediately; next fetch runs normally.
REQ-035 SHALL test OPW=6, opcode 6'h14: decodes as NOP, returns to T0 after T2.
